// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Latency: accept at edge k -> rsp_valid high after edge k+EXEC_CYCLES; issue interval EXEC_CYCLES+2.
// Backpressure: rsp_* held while rsp_ready is low; no request is accepted until the response drains.
module alu_request_arbiter #(
  parameter int WIDTH       = 16,
  parameter int EXEC_CYCLES = 1   // ALU settle cycles, legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // shared combinational ALU
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_err,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is loaded with EXEC_CYCLES-1 so that the capture happens on the
  // EXEC_CYCLES-th edge after the accept edge.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       alu_operation_q, alu_operation_d;
  logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_neg_q, rsp_neg_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic             grant0;
  logic             grant1;

  // Round-robin choice: a lone requester wins; on contention the one that did
  // not win last time wins. Ready is only offered while idle.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == IDLE) && grant0;
    req1_ready = (state_q == IDLE) && grant1;
  end

  // Next-state logic: accept and latch in IDLE, count down in EXEC, drain in RESP.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    alu_operation_d = alu_operation_q;
    alu_op1_d       = alu_op1_q;
    alu_op2_d       = alu_op2_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_res_d       = rsp_res_q;
    rsp_zero_d      = rsp_zero_q;
    rsp_neg_d       = rsp_neg_q;
    rsp_err_d       = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d         = EXEC;
          cnt_d           = CNT_LOAD;
          last_grant_d    = req1_ready;
          rsp_id_d        = req1_ready;
          alu_operation_d = req1_ready ? req1_op : req0_op;
          alu_op1_d       = req1_ready ? req1_a  : req0_a;
          alu_op2_d       = req1_ready ? req1_b  : req0_b;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // On an ALU error the result bus is not trusted; report zero instead.
          rsp_res_d   = alu_err ? '0 : alu_res;
          rsp_zero_d  = alu_zero;
          rsp_neg_d   = alu_neg;
          rsp_err_d   = alu_err;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      cnt_q           <= '0;
      alu_operation_q <= '0;
      alu_op1_q       <= '0;
      alu_op2_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_res_q       <= '0;
      rsp_zero_q      <= 1'b0;
      rsp_neg_q       <= 1'b0;
      rsp_err_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      cnt_q           <= cnt_d;
      alu_operation_q <= alu_operation_d;
      alu_op1_q       <= alu_op1_d;
      alu_op2_q       <= alu_op2_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_res_q       <= rsp_res_d;
      rsp_zero_q      <= rsp_zero_d;
      rsp_neg_q       <= rsp_neg_d;
      rsp_err_q       <= rsp_err_d;
      busy_q          <= busy_d;
    end
  end

  // Output wiring.
  always_comb begin
    alu_operation = alu_operation_q;
    alu_op1       = alu_op1_q;
    alu_op2       = alu_op2_q;
    rsp_valid     = rsp_valid_q;
    rsp_id        = rsp_id_q;
    rsp_res       = rsp_res_q;
    rsp_zero      = rsp_zero_q;
    rsp_neg       = rsp_neg_q;
    rsp_err       = rsp_err_q;
    busy          = busy_q;
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb_alu_request_arbiter: directed bench for the ALU request arbiter with a scoreboard.
// Two instances: EXEC_CYCLES=1 (main) and EXEC_CYCLES=4 (settle-time checks).
// A behavioural ALU closes the loop on both instances.
module tb_alu_request_arbiter;

  logic clk;
  logic rst_n;

  // main instance (EXEC_CYCLES = 1)
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_operation;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_op1, alu_op2, alu_res, rsp_res;
  logic        alu_zero, alu_neg, alu_err;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_neg, rsp_err, busy;

  // second instance (EXEC_CYCLES = 4)
  logic        req0_valid_4, req0_ready_4, req1_valid_4, req1_ready_4;
  logic [3:0]  req0_op_4, req1_op_4, alu_operation_4;
  logic [15:0] req0_a_4, req0_b_4, req1_a_4, req1_b_4, alu_op1_4, alu_op2_4, alu_res_4, rsp_res_4;
  logic        alu_zero_4, alu_neg_4, alu_err_4;
  logic        rsp_valid_4, rsp_ready_4, rsp_id_4, rsp_zero_4, rsp_neg_4, rsp_err_4, busy_4;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        zero;
    logic        neg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Behavioural ALU: returns {err, neg, zero, res}; garbage result on error.
  function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = ~a;
      4'd4:  r = a << b[3:0];
      4'd5:  r = a >> b[3:0];
      4'd6:  r = $signed(a) >>> b[3:0];
      4'd7:  r = a * b;
      4'd8:  r = a + b;
      4'd9:  r = a - b;
      4'd10: begin
        if (b == 16'd0) begin
          e = 1'b1;
          r = 16'hDEAD;
        end else begin
          r = a / b;
        end
      end
      default: begin
        e = 1'b1;
        r = 16'hDEAD;
      end
    endcase
    return {e, r[15], (r == 16'd0), r};
  endfunction

  function automatic exp_t mk_exp(input logic id, input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b);
    logic [18:0] m;
    exp_t        x;
    m      = alu_model(op, a, b);
    x.id   = id;
    x.res  = m[18] ? 16'h0000 : m[15:0];
    x.zero = m[16];
    x.neg  = m[17];
    x.err  = m[18];
    return x;
  endfunction

  assign {alu_err, alu_neg, alu_zero, alu_res}         = alu_model(alu_operation, alu_op1, alu_op2);
  assign {alu_err_4, alu_neg_4, alu_zero_4, alu_res_4} = alu_model(alu_operation_4, alu_op1_4, alu_op2_4);

  alu_request_arbiter #(.WIDTH(16), .EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_operation(alu_operation), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .busy(busy)
  );

  alu_request_arbiter #(.WIDTH(16), .EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid_4), .req0_ready(req0_ready_4), .req0_op(req0_op_4), .req0_a(req0_a_4), .req0_b(req0_b_4),
    .req1_valid(req1_valid_4), .req1_ready(req1_ready_4), .req1_op(req1_op_4), .req1_a(req1_a_4), .req1_b(req1_b_4),
    .alu_operation(alu_operation_4), .alu_op1(alu_op1_4), .alu_op2(alu_op2_4),
    .alu_res(alu_res_4), .alu_zero(alu_zero_4), .alu_neg(alu_neg_4), .alu_err(alu_err_4),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_id(rsp_id_4), .rsp_res(rsp_res_4),
    .rsp_zero(rsp_zero_4), .rsp_neg(rsp_neg_4), .rsp_err(rsp_err_4), .busy(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: inputs are stable at the falling edge, so a handshake
  // seen here is the one the next rising edge performs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) sb.push_back(mk_exp(1'b0, req0_op, req0_a, req0_b));
      if (req1_valid && req1_ready) sb.push_back(mk_exp(1'b1, req1_op, req1_a, req1_b));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_rsp_id",   32'(rsp_id),   32'(mon_e.id));
          chk("sb_rsp_res",  32'(rsp_res),  32'(mon_e.res));
          chk("sb_rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
          chk("sb_rsp_neg",  32'(rsp_neg),  32'(mon_e.neg));
          chk("sb_rsp_err",  32'(rsp_err),  32'(mon_e.err));
        end
      end
    end
  end

  logic [3:0]  t0_op[3] = '{4'd8, 4'd0, 4'd9};
  logic [15:0] t0_a[3]  = '{16'h0100, 16'hF0F0, 16'h0001};
  logic [15:0] t0_b[3]  = '{16'h0023, 16'h0FF0, 16'h0002};
  logic [3:0]  t1_op[3] = '{4'd2, 4'd9, 4'd10};
  logic [15:0] t1_a[3]  = '{16'hAAAA, 16'h0005, 16'd100};
  logic [15:0] t1_b[3]  = '{16'h5555, 16'h0005, 16'd7};

  initial begin
    logic [15:0] snap_res;
    logic        snap_id, snap_err;
    logic        gq[$];
    int          gc[$];
    int          i0, i1, cyc;

    rst_n = 1'b0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 0;
    req0_valid_4 = 0; req0_op_4 = 0; req0_a_4 = 0; req0_b_4 = 0;
    req1_valid_4 = 0; req1_op_4 = 0; req1_a_4 = 0; req1_b_4 = 0;
    rsp_ready_4 = 0;

    // reset state
    #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_alu_op",    32'(alu_operation), 32'd0);
    chk("rst_alu_a",     32'(alu_op1),   32'd0);
    chk("rst_alu_b",     32'(alu_op2),   32'd0);
    chk("rst_rsp_res",   32'(rsp_res),   32'd0);
    chk("rst_req_ready", 32'({req0_ready, req1_ready}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single add from req0
    req0_valid = 1; req0_op = 4'b1000; req0_a = 16'h0003; req0_b = 16'h0004;
    #1;
    chk("add_req0_ready", 32'(req0_ready), 32'd1);
    chk("add_req1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 0;
    chk("add_busy_exec",  32'(busy),          32'd1);
    chk("add_alu_op",     32'(alu_operation), 32'h8);
    chk("add_alu_a",      32'(alu_op1),       32'h3);
    chk("add_alu_b",      32'(alu_op2),       32'h4);
    chk("add_no_rsp_yet", 32'(rsp_valid),     32'd0);
    step();
    chk("add_rsp_valid",  32'(rsp_valid), 32'd1);
    chk("add_rsp_id",     32'(rsp_id),    32'd0);
    chk("add_rsp_res",    32'(rsp_res),   32'h0007);
    chk("add_rsp_zero",   32'(rsp_zero),  32'd0);
    chk("add_rsp_err",    32'(rsp_err),   32'd0);
    chk("add_busy_resp",  32'(busy),      32'd1);
    rsp_ready = 1;
    step();
    chk("add_rsp_cleared", 32'(rsp_valid), 32'd0);
    chk("add_busy_idle",   32'(busy),      32'd0);

    // divide by zero from req1, then hold the response for 5 cycles
    rsp_ready = 0;
    req1_valid = 1; req1_op = 4'b1010; req1_a = 16'h0010; req1_b = 16'h0000;
    #1;
    chk("div_req1_ready", 32'(req1_ready), 32'd1);
    step();
    // both requesters now wait with their first back-to-back ops
    req0_valid = 1; req0_op = t0_op[0]; req0_a = t0_a[0]; req0_b = t0_b[0];
    req1_valid = 1; req1_op = t1_op[0]; req1_a = t1_a[0]; req1_b = t1_b[0];
    step();
    chk("div_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("div_rsp_id",    32'(rsp_id),    32'd1);
    chk("div_rsp_err",   32'(rsp_err),   32'd1);
    chk("div_rsp_res",   32'(rsp_res),   32'h0000);
    snap_res = rsp_res; snap_id = rsp_id; snap_err = rsp_err;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_res_stable", 32'({snap_id, snap_err, snap_res}), 32'({rsp_id, rsp_err, rsp_res}));
      chk("bp_no_ready",   32'({req0_ready, req1_ready}), 32'd0);
      step();
    end
    rsp_ready = 1;
    #1;
    chk("bp_no_accept_at_rsp_hs", 32'({req0_ready, req1_ready}), 32'd0);

    // simultaneous back-to-back requests, round-robin from req0
    i0 = 0; i1 = 0; cyc = 0;
    while ((i0 < 3 || i1 < 3) && cyc < 60) begin
      req0_valid = (i0 < 3);
      if (i0 < 3) begin req0_op = t0_op[i0]; req0_a = t0_a[i0]; req0_b = t0_b[i0]; end
      req1_valid = (i1 < 3);
      if (i1 < 3) begin req1_op = t1_op[i1]; req1_a = t1_a[i1]; req1_b = t1_b[i1]; end
      #1;
      if (req0_ready && req1_ready) chk("rr_one_hot_ready", 32'd2, 32'd1);
      if (req0_ready) begin gq.push_back(1'b0); gc.push_back(cyc); i0++; end
      if (req1_ready) begin gq.push_back(1'b1); gc.push_back(cyc); i1++; end
      step();
      cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_grant_count", 32'(gq.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < gq.size()) chk("rr_grant_order", 32'(gq[k]), 32'(k % 2));
    end
    for (int k = 1; k < 6; k++) begin
      if (k < gc.size()) chk("rr_issue_interval", 32'(gc[k] - gc[k-1]), 32'd3);
    end
    drain();

    // illegal op code
    req0_valid = 1; req0_op = 4'b1111; req0_a = 16'h1234; req0_b = 16'h0001;
    step();
    req0_valid = 0;
    wait_rsp("illegal");
    chk("illegal_rsp_err", 32'(rsp_err), 32'd1);
    chk("illegal_rsp_res", 32'(rsp_res), 32'h0000);
    chk("illegal_rsp_id",  32'(rsp_id),  32'd0);
    drain();

    // EXEC_CYCLES=4: operands held for 4 cycles, response exactly 4 edges later
    rsp_ready_4 = 1;
    req0_valid_4 = 1; req0_op_4 = 4'd2; req0_a_4 = 16'h1234; req0_b_4 = 16'h00FF;
    #1;
    chk("x4_req0_ready", 32'(req0_ready_4), 32'd1);
    step();
    req0_valid_4 = 0;
    for (int k = 0; k < 4; k++) begin
      chk("x4_alu_op_held", 32'(alu_operation_4), 32'd2);
      chk("x4_alu_a_held",  32'(alu_op1_4), 32'h1234);
      chk("x4_alu_b_held",  32'(alu_op2_4), 32'h00FF);
      chk("x4_no_rsp_yet",  32'(rsp_valid_4), 32'd0);
      chk("x4_busy",        32'(busy_4), 32'd1);
      step();
    end
    chk("x4_rsp_valid", 32'(rsp_valid_4), 32'd1);
    chk("x4_rsp_res",   32'(rsp_res_4),   32'h12CB);
    chk("x4_rsp_id",    32'(rsp_id_4),    32'd0);
    step();
    chk("x4_rsp_cleared", 32'(rsp_valid_4), 32'd0);

    // asynchronous reset in the middle of EXEC
    req0_valid = 1; req0_op = 4'd8; req0_a = 16'h0001; req0_b = 16'h0001;
    req0_valid_4 = 1; req0_op_4 = 4'd1; req0_a_4 = 16'h00F0; req0_b_4 = 16'h000F;
    step();
    req0_valid = 0; req0_valid_4 = 0;
    chk("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_busy",      32'(busy),          32'd0);
    chk("mid_rst_alu_op",    32'(alu_operation), 32'd0);
    chk("mid_rst_alu_a",     32'(alu_op1),       32'd0);
    chk("mid_rst_alu_b",     32'(alu_op2),       32'd0);
    chk("mid_rst_rsp",       32'({rsp_valid, rsp_id, rsp_zero, rsp_neg, rsp_err}), 32'd0);
    chk("mid_rst_rsp_res",   32'(rsp_res),       32'd0);
    chk("mid_rst_busy4",     32'(busy_4),        32'd0);
    chk("mid_rst_alu4",      32'({alu_operation_4, alu_op1_4, alu_op2_4}), 32'd0);
    chk("mid_rst_rsp4",      32'({rsp_valid_4, rsp_id_4, rsp_zero_4, rsp_neg_4, rsp_err_4}), 32'd0);
    chk("mid_rst_rsp_res4",  32'(rsp_res_4),     32'd0);
    chk("mid_rst_ready4",    32'({req0_ready_4, req1_ready_4}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mid_no_rsp_after", 32'({rsp_valid, rsp_valid_4}), 32'd0);
    end
    req0_valid = 1; req0_op = 4'd8; req0_a = 16'h0010; req0_b = 16'h0020;
    req1_valid = 1; req1_op = 4'd9; req1_a = 16'h0010; req1_b = 16'h0020;
    #1;
    chk("post_rst_req0_first", 32'(req0_ready), 32'd1);
    chk("post_rst_req1_wait",  32'(req1_ready), 32'd0);
    step();
    req0_valid = 0; req1_valid = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
- Shares the single combinational 16-bit ALU between two requesters, e.g. the execute stage and a background address/maths unit.
- Arbitrates round-robin and latches the winner's operation and operands.
- Drives the ALU from stable registers for a programmable settle time, then captures the result and flags.
- Returns the result on one response channel tagged with the requester ID, using valid/ready handshakes on every channel.

Parameters:
- WIDTH, 16: operand and result width; must match the ALU.
- EXEC_CYCLES, 1: clock cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_op  in  4  ALU operation code (0000 and .. 1010 div)
- req0_a  in  WIDTH  operand 1
- req0_b  in  WIDTH  operand 2
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as requester 0, for requester 1
- alu_operation  out  4  to ALU operation
- alu_op1  out  WIDTH  to ALU operand 1
- alu_op2  out  WIDTH  to ALU operand 2
- alu_res  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- alu_err  in  1  ALU error flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_res  out  WIDTH  result
- rsp_zero / rsp_neg / rsp_err  out  1  captured flags
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (async, rst_n low): state IDLE, last_grant=1 (so req0 wins first).
- Also zeroed at reset: all alu_* outputs, all rsp_* outputs, busy, and the cycle counter.
- Reset mid-transaction drops the operation silently; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE, ready rules:
  - req0_ready/req1_ready are combinational and asserted only in IDLE.
  - At most one is high.
  - If only one valid, that requester gets ready.
  - If both valid, the requester that is not last_grant gets ready.
  - If none valid, neither gets ready.
- IDLE, handshake: on valid&ready at a rising edge:
  - latch op/a/b into alu_operation/alu_op1/alu_op2;
  - latch the winner ID into rsp_id and last_grant;
  - load counter with EXEC_CYCLES-1;
  - go to EXEC.
- A requester may drop valid without a handshake; this has no effect.
- EXEC:
  - alu_* outputs are held constant.
  - If counter != 0, decrement.
  - If counter == 0:
    - capture alu_zero/alu_neg/alu_err into rsp_*;
    - capture rsp_res = alu_err ? 0 : alu_res, so no X propagates downstream;
    - set rsp_valid=1 and go to RESP.
- RESP:
  - rsp_* are held stable while rsp_ready is low.
  - On rsp_valid&rsp_ready: clear rsp_valid, go to IDLE.
- No new request is accepted in the same cycle as the response handshake.
- Latency: request handshake at edge k -> rsp_valid high after edge k+EXEC_CYCLES.
- Minimum issue interval is EXEC_CYCLES+2 cycles with rsp_ready tied high.
- The ALU is combinational; this block does no arithmetic.
- Width rules: operands pass through unchanged; op code passes through unchanged.
- Illegal op codes (1011..1111) are forwarded; the ALU's error flag is reported as rsp_err=1 with rsp_res=0.
- alu_* outputs keep their last latched values in IDLE and RESP; they change only at an accept edge.
- busy = (state != IDLE), registered.

Test Plan:
- Add, single requester: after reset, req0 add (op 1000) a=0x0003 b=0x0004.
  - req0_ready=1 in cycle 0.
  - rsp_valid rises 1 cycle after accept with rsp_id=0, rsp_res=0x0007, zero=0, err=0.
  - busy high through RESP.
- Simultaneous requests: req0 and req1 valid in the same cycle, each with 3 back-to-back ops, rsp_ready=1.
  - Grants alternate 0,1,0,1,0,1.
  - The first grant goes to req0.
  - Each response's rsp_id matches its originating request.
- Divide by zero: req1 div (op 1010) a=0x0010 b=0x0000.
  - Response: rsp_err=1, rsp_res=0x0000, rsp_id=1.
- Illegal op: op 1111 also gives rsp_err=1, rsp_res=0x0000.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises.
  - rsp_* stable throughout; both req*_ready stay 0.
  - Handshake on cycle 6; the next request is accepted no earlier than the following cycle.
- EXEC_CYCLES=4: alu_op1/alu_op2/alu_operation remain constant for 4 cycles; rsp_valid rises exactly 4 cycles after accept.
- Reset mid-EXEC: pull rst_n low asynchronously between edges.
  - All outputs go to 0 immediately, with no rsp_valid afterwards.
  - After release, the next simultaneous request is granted to req0.
